// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline back end: widths, control bundle,
// the hard-wired zero register and the register-file write qualifier.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    // Control bits carried from decode through execute into memory/write-back.
    typedef struct packed {
        logic MW;   // MemWr
        logic BR;   // Branch
        logic MR;   // MemtoReg
        logic RW;   // RegWr
    } ctrl_t;

    localparam logic [REG_W-1:0] R0 = 5'd0;

    // A register write is real only if requested and not aimed at r0
    // (unless r0 writes are explicitly allowed).
    function automatic logic rf_write_ok(input logic we,
                                         input logic [REG_W-1:0] rw,
                                         input logic allow_r0);
        return we & (allow_r0 | (rw != R0));
    endfunction

endpackage

// File: rtl/mem_wb_unit_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [WORD_W-1:0]     i_wdata,
    output logic [WORD_W-1:0]     o_rdata
);

    logic [WORD_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

    // Store port: one word per enabled clock edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_unit.sv
// Back half of the 5-stage MIPS pipeline: EX/MEM register, data-memory
// access, MEM/WB register and register-file write-back, plus branch and
// forwarding information taken from the EX/MEM stage.
module mem_wb_unit
    import mips_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter bit REG_ZERO_WE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ALUout,
    input  logic [WORD_W-1:0] BB,
    input  logic [REG_W-1:0]  Rw_out,
    input  logic [WORD_W-1:0] newPC,
    input  logic              Zero,
    input  logic              Overflow,
    input  logic              MW,
    input  logic              BR,
    input  logic              MR,
    input  logic              RW,
    output logic [REG_W-1:0]  Rw,
    output logic [WORD_W-1:0] Di,
    output logic              WE,
    output logic              pc_src,
    output logic [WORD_W-1:0] branch_target,
    output logic [REG_W-1:0]  fwd_mem_rw,
    output logic              fwd_mem_we,
    output logic [WORD_W-1:0] fwd_mem_data
);

    // EX/MEM pipeline register
    logic              r_em_valid;
    ctrl_t             r_em_ctrl;
    logic [WORD_W-1:0] r_em_alu;
    logic [WORD_W-1:0] r_em_bb;
    logic [REG_W-1:0]  r_em_rw;
    logic [WORD_W-1:0] r_em_newpc;
    logic              r_em_zero;
    logic              r_em_ovf;

    // MEM/WB pipeline register
    logic [WORD_W-1:0] r_wb_data;
    logic [REG_W-1:0]  r_wb_rw;
    logic              r_wb_we;

    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_idx;
    logic [WORD_W-1:0]     w_mem_rdata;
    logic [WORD_W-1:0]     w_wb_data_next;

    // Byte address to word index; upper bits wrap modulo the depth.
    assign w_mem_idx = r_em_alu[DEPTH_LOG2+1:2];
    // A stalled or reset cycle must not commit the store, otherwise it
    // would be repeated once the stall releases.
    assign w_mem_we  = r_em_valid & r_em_ctrl.MW & ~stall & ~reset;

    data_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_idx),
        .i_wdata (r_em_bb),
        .o_rdata (w_mem_rdata)
    );

    assign w_wb_data_next = r_em_ctrl.MR ? w_mem_rdata : r_em_alu;

    // EX/MEM capture: reset clears, stall holds, otherwise take execute results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_em_valid <= 1'b0;
            r_em_ctrl  <= '0;
            r_em_alu   <= 32'd0;
            r_em_bb    <= 32'd0;
            r_em_rw    <= 5'd0;
            r_em_newpc <= 32'd0;
            r_em_zero  <= 1'b0;
            r_em_ovf   <= 1'b0;
        end else if (!stall) begin
            r_em_valid <= ex_valid;
            r_em_ctrl  <= '{MW: MW, BR: BR, MR: MR, RW: RW};
            r_em_alu   <= ALUout;
            r_em_bb    <= BB;
            r_em_rw    <= Rw_out;
            r_em_newpc <= newPC;
            r_em_zero  <= Zero;
            r_em_ovf   <= Overflow;
        end
    end

    // MEM/WB capture: overflow or a bubble kills the register write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_data <= 32'd0;
            r_wb_rw   <= 5'd0;
            r_wb_we   <= 1'b0;
        end else if (!stall) begin
            r_wb_data <= w_wb_data_next;
            r_wb_rw   <= r_em_rw;
            r_wb_we   <= r_em_valid & r_em_ctrl.RW & ~r_em_ovf;
        end
    end

    // Write-back port
    assign Rw = r_wb_rw;
    assign Di = r_wb_data;
    assign WE = rf_write_ok(r_wb_we, r_wb_rw, REG_ZERO_WE);

    // Branch resolution from the EX/MEM stage
    assign pc_src        = r_em_valid & r_em_ctrl.BR & r_em_zero;
    assign branch_target = r_em_newpc;

    // Forwarding: loads are excluded because their data is not ready yet.
    assign fwd_mem_rw   = r_em_rw;
    assign fwd_mem_we   = r_em_valid & r_em_ctrl.RW & ~r_em_ctrl.MR & ~r_em_ovf;
    assign fwd_mem_data = r_em_alu;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Self-checking bench for mem_wb_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_mem_wb_unit;

    logic        clk = 1'b0;
    logic        reset, stall, ex_valid, Zero, Overflow, MW, BR, MR, RW;
    logic [31:0] ALUout, BB, newPC;
    logic [4:0]  Rw_out;
    logic [4:0]  Rw, fwd_mem_rw;
    logic [31:0] Di, branch_target, fwd_mem_data;
    logic        WE, pc_src, fwd_mem_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .ALUout(ALUout), .BB(BB), .Rw_out(Rw_out), .newPC(newPC),
        .Zero(Zero), .Overflow(Overflow), .MW(MW), .BR(BR), .MR(MR), .RW(RW),
        .Rw(Rw), .Di(Di), .WE(WE), .pc_src(pc_src), .branch_target(branch_target),
        .fwd_mem_rw(fwd_mem_rw), .fwd_mem_we(fwd_mem_we), .fwd_mem_data(fwd_mem_data)
    );

    typedef struct {
        logic        valid;
        logic [31:0] alu, bb, newpc;
        logic [4:0]  rw;
        logic        zero, ovf, mw, br, mr, rgw;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        exp_pc;
        logic        exp_fwe;
        logic        exp_we;
        logic [4:0]  exp_rw;
        logic [31:0] exp_di;
    } vec_t;

    // ---------------- reference model ----------------
    instr_t      cur;
    instr_t      m_em;
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rw;
    logic        m_wb_we;
    logic [31:0] m_mem [256];

    function automatic instr_t mk(logic v, logic [31:0] alu, logic [31:0] bb,
                                  logic [4:0] rw, logic mw, logic mr, logic rgw,
                                  logic br, logic z, logic ovf, logic [31:0] npc);
        instr_t x;
        x.valid = v; x.alu = alu; x.bb = bb; x.rw = rw; x.mw = mw; x.mr = mr;
        x.rgw = rgw; x.br = br; x.zero = z; x.ovf = ovf; x.newpc = npc;
        return x;
    endfunction

    function automatic instr_t bubble();
        return mk(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endfunction

    task automatic drive(input instr_t x);
        cur = x;
        ex_valid = x.valid; ALUout = x.alu; BB = x.bb; Rw_out = x.rw; newPC = x.newpc;
        Zero = x.zero; Overflow = x.ovf; MW = x.mw; BR = x.br; MR = x.mr; RW = x.rgw;
    endtask

    // What one clock edge does to the architectural state, from the rules.
    task automatic model_edge();
        int idx;
        if (reset) begin
            m_em = bubble(); m_wb_data = 32'd0; m_wb_rw = 5'd0; m_wb_we = 1'b0;
        end else if (!stall) begin
            idx = int'(m_em.alu / 32'd4) % 256;
            m_wb_data = m_em.mr ? m_mem[idx] : m_em.alu;
            m_wb_rw   = m_em.rw;
            m_wb_we   = m_em.valid && m_em.rgw && !m_em.ovf;
            if (m_em.valid && m_em.mw) m_mem[idx] = m_em.bb;
            m_em = cur;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m_Rw", {27'd0, Rw}, {27'd0, m_wb_rw});
        chk("m_Di", Di, m_wb_data);
        chk("m_WE", {31'd0, WE}, {31'd0, (m_wb_we && m_wb_rw != 5'd0)});
        chk("m_pc_src", {31'd0, pc_src}, {31'd0, (m_em.valid && m_em.br && m_em.zero)});
        chk("m_bt", branch_target, m_em.newpc);
        chk("m_fwd_rw", {27'd0, fwd_mem_rw}, {27'd0, m_em.rw});
        chk("m_fwd_we", {31'd0, fwd_mem_we},
            {31'd0, (m_em.valid && m_em.rgw && !m_em.mr && !m_em.ovf)});
        chk("m_fwd_data", fwd_mem_data, m_em.alu);
    endtask

    task automatic chk_wb(input string nm, input logic we, input logic [4:0] rw, input logic [31:0] di);
        chk({nm, "_WE"}, {31'd0, WE}, {31'd0, we});
        chk({nm, "_Rw"}, {27'd0, Rw}, {27'd0, rw});
        chk({nm, "_Di"}, Di, di);
    endtask

    vec_t vecs [12];

    initial begin
        m_em = bubble(); m_wb_data = 32'd0; m_wb_rw = 5'd0; m_wb_we = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
        reset = 1'b1; stall = 1'b0;
        drive(bubble());

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 2; i++) begin
            drive(mk(1'b1, $urandom, $urandom, 5'($urandom), 1'b0, 1'($urandom), 1'b1,
                     1'b1, 1'b1, 1'b0, $urandom));
            cycle();
            chk_wb("rst", 1'b0, 5'd0, 32'd0);
            chk("rst_pc_src", {31'd0, pc_src}, 32'd0);
            chk("rst_bt", branch_target, 32'd0);
            chk("rst_fwd_we", {31'd0, fwd_mem_we}, 32'd0);
        end
        reset = 1'b0;
        drive(mk(1'b1, $urandom, $urandom, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom));
        cycle();
        chk_wb("rst_rel", 1'b0, 5'd0, 32'd0);
        drive(bubble());
        cycle();
        cycle();

        // ---------------- directed vector table ----------------
        //                  v     alu           bb            rw     mw    mr    rgw   br    z     ovf   npc
        vecs[0].in  = mk(1'b1, 32'h7,        32'h0,        5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[1].in  = mk(1'b1, 32'h10,       32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[2].in  = mk(1'b1, 32'h10,       32'h0,        5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[3].in  = mk(1'b1, 32'h410,      32'h0,        5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[4].in  = mk(1'b1, 32'h13,       32'h0,        5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[5].in  = mk(1'b1, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
        vecs[6].in  = mk(1'b1, 32'h4,        32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80);
        vecs[7].in  = mk(1'b0, 32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44);
        vecs[8].in  = mk(1'b1, 32'h5,        32'h0,        5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        vecs[9].in  = mk(1'b1, 32'h8,        32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[10].in = mk(1'b1, 32'h20,       32'h12345678, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        vecs[11].in = mk(1'b0, 32'h20,       32'h00000BAD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[0].exp_pc = 1'b0; vecs[0].exp_fwe = 1'b1; vecs[0].exp_we = 1'b1; vecs[0].exp_rw = 5'd9; vecs[0].exp_di = 32'h7;
        vecs[1].exp_pc = 1'b0; vecs[1].exp_fwe = 1'b0; vecs[1].exp_we = 1'b0; vecs[1].exp_rw = 5'd0; vecs[1].exp_di = 32'h10;
        vecs[2].exp_pc = 1'b0; vecs[2].exp_fwe = 1'b0; vecs[2].exp_we = 1'b1; vecs[2].exp_rw = 5'd4; vecs[2].exp_di = 32'hDEADBEEF;
        vecs[3].exp_pc = 1'b0; vecs[3].exp_fwe = 1'b0; vecs[3].exp_we = 1'b1; vecs[3].exp_rw = 5'd5; vecs[3].exp_di = 32'hDEADBEEF;
        vecs[4].exp_pc = 1'b0; vecs[4].exp_fwe = 1'b0; vecs[4].exp_we = 1'b1; vecs[4].exp_rw = 5'd6; vecs[4].exp_di = 32'hDEADBEEF;
        vecs[5].exp_pc = 1'b1; vecs[5].exp_fwe = 1'b0; vecs[5].exp_we = 1'b0; vecs[5].exp_rw = 5'd0; vecs[5].exp_di = 32'h0;
        vecs[6].exp_pc = 1'b0; vecs[6].exp_fwe = 1'b0; vecs[6].exp_we = 1'b0; vecs[6].exp_rw = 5'd0; vecs[6].exp_di = 32'h4;
        vecs[7].exp_pc = 1'b0; vecs[7].exp_fwe = 1'b0; vecs[7].exp_we = 1'b0; vecs[7].exp_rw = 5'd0; vecs[7].exp_di = 32'h0;
        vecs[8].exp_pc = 1'b0; vecs[8].exp_fwe = 1'b0; vecs[8].exp_we = 1'b0; vecs[8].exp_rw = 5'd3; vecs[8].exp_di = 32'h5;
        vecs[9].exp_pc = 1'b0; vecs[9].exp_fwe = 1'b1; vecs[9].exp_we = 1'b0; vecs[9].exp_rw = 5'd0; vecs[9].exp_di = 32'h8;
        vecs[10].exp_pc = 1'b0; vecs[10].exp_fwe = 1'b0; vecs[10].exp_we = 1'b0; vecs[10].exp_rw = 5'd0; vecs[10].exp_di = 32'h20;
        vecs[11].exp_pc = 1'b0; vecs[11].exp_fwe = 1'b0; vecs[11].exp_we = 1'b0; vecs[11].exp_rw = 5'd0; vecs[11].exp_di = 32'h20;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].in);
            cycle();
            chk($sformatf("v%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_pc});
            chk($sformatf("v%0d_bt", i), branch_target, vecs[i].in.newpc);
            chk($sformatf("v%0d_fwd_we", i), {31'd0, fwd_mem_we}, {31'd0, vecs[i].exp_fwe});
            chk($sformatf("v%0d_fwd_rw", i), {27'd0, fwd_mem_rw}, {27'd0, vecs[i].in.rw});
            chk($sformatf("v%0d_fwd_data", i), fwd_mem_data, vecs[i].in.alu);
            drive(bubble());
            cycle();
            chk_wb($sformatf("v%0d", i), vecs[i].exp_we, vecs[i].exp_rw, vecs[i].exp_di);
            chk($sformatf("v%0d_pc_src_off", i), {31'd0, pc_src}, 32'd0);
        end
        // overflowed store and the ignored bubble store: word 0x20 holds 0x12345678
        drive(mk(1'b1, 32'h20, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle(); drive(bubble()); cycle();
        chk_wb("ovf_store", 1'b1, 5'd7, 32'h12345678);

        // ---------------- store then load back-to-back ----------------
        drive(mk(1'b1, 32'h50, 32'hA5A5A5A5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(mk(1'b1, 32'h50, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(bubble());
        cycle();
        chk_wb("st_ld", 1'b1, 5'd4, 32'hA5A5A5A5);

        // ---------------- load then store back-to-back ----------------
        drive(mk(1'b1, 32'h50, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(mk(1'b1, 32'h50, 32'h5A5A5A5A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        chk_wb("ld_st_old", 1'b1, 5'd5, 32'hA5A5A5A5);
        drive(mk(1'b1, 32'h50, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(bubble());
        cycle();
        chk_wb("ld_st_new", 1'b1, 5'd6, 32'h5A5A5A5A);

        // ---------------- stall during a store ----------------
        drive(mk(1'b1, 32'h77, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(mk(1'b1, 32'h30, 32'hCAFE0001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        stall = 1'b1;
        drive(mk(1'b1, 32'h30, 32'h11111111, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_wb($sformatf("stall%0d", i), 1'b1, 5'd7, 32'h77);
            chk($sformatf("stall%0d_fwd_data", i), fwd_mem_data, 32'h30);
        end
        stall = 1'b0;
        drive(bubble());
        cycle();
        drive(mk(1'b1, 32'h30, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(bubble());
        cycle();
        chk_wb("stall_store", 1'b1, 5'd2, 32'hCAFE0001);

        // ---------------- reset in the middle of a stall ----------------
        drive(mk(1'b1, 32'h88, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h99));
        cycle();
        cycle();
        stall = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        chk_wb("rst_stall", 1'b0, 5'd0, 32'd0);
        chk("rst_stall_pc", {31'd0, pc_src}, 32'd0);
        chk("rst_stall_bt", branch_target, 32'd0);
        chk("rst_stall_fwd", fwd_mem_data, 32'd0);
        reset = 1'b0; stall = 1'b0;
        drive(mk(1'b1, 32'h30, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        cycle();
        drive(bubble());
        cycle();
        chk_wb("rst_mem_kept", 1'b1, 5'd2, 32'hCAFE0001);

        // ---------------- fill memory, then random traffic ----------------
        for (int i = 0; i < 256; i++) begin
            drive(mk(1'b1, 32'(i) * 32'd4, $urandom, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
            cycle();
        end
        drive(bubble());
        cycle();
        check_model();

        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            reset = (r < 2);
            stall = (r >= 2 && r < 17);
            a = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0C1F) : $urandom;
            drive(mk(($urandom_range(0, 3) != 0), a, $urandom,
                     ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0), $urandom));
            cycle();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Back half of the 5-stage MIPS pipeline, between the execute unit and the register file write port.
- Registers the execute results (EX/MEM), performs the data-memory access, registers the result (MEM/WB), and drives Rw/Di/WE back to the register file.
- Also returns the branch decision to fetch and exposes EX/MEM and MEM/WB destination info for forwarding.

Parameters:
- DEPTH_LOG2, 8, log2 of data-memory depth in 32-bit words (256 words).
- REG_ZERO_WE, 0, when 0, writes to register 0 are suppressed.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold both pipeline registers; no memory write.
- ex_valid  in  1  execute stage holds a real instruction (0 = bubble).
- ALUout  in  32  ALU result / memory byte address.
- BB  in  32  store data (forwarded busB).
- Rw_out  in  5  destination register selected in execute.
- newPC  in  32  branch target.
- Zero  in  1  ALU zero flag.
- Overflow  in  1  ALU signed overflow.
- MW  in  1  MemWr.
- BR  in  1  Branch.
- MR  in  1  MemtoReg.
- RW  in  1  RegWr.
- Rw  out  5  register-file write address.
- Di  out  32  register-file write data.
- WE  out  1  register-file write enable.
- pc_src  out  1  branch taken, to fetch.
- branch_target  out  32  registered newPC.
- fwd_mem_rw  out  5  EX/MEM destination register.
- fwd_mem_we  out  1  EX/MEM will write a register.
- fwd_mem_data  out  32  EX/MEM ALU result.

Behaviour:
- EX/MEM register captures all inputs on a rising clk when !stall. Its valid bit is ex_valid & !reset.
- Memory word index = em_ALUout[DEPTH_LOG2+1:2]. Low 2 bits are ignored; upper bits wrap modulo depth.
- Memory write occurs on a rising clk when em_valid & em_MW & !stall & !reset.
- Memory read is combinational from the EX/MEM address.
- MEM/WB register captures when !stall:
  - wb_data = em_MR ? mem_rdata : em_ALUout.
  - wb_rw = em_Rw.
  - wb_we = em_valid & em_RW & !em_Overflow.
- Write-back outputs:
  - Rw = wb_rw.
  - Di = wb_data.
  - WE = wb_we & (REG_ZERO_WE | wb_rw != 0).
  - Latency: execute inputs sampled at edge N produce WE/Rw/Di valid after edge N+1, so the register file writes at edge N+2.
- Branch: pc_src = em_valid & em_BR & em_Zero (combinational from EX/MEM). branch_target = em_newPC.
- Forwarding: fwd_mem_rw = em_Rw; fwd_mem_we = em_valid & em_RW & !em_MR & !em_Overflow; fwd_mem_data = em_ALUout.
- Overflow: the instruction still flows through, but its register write is killed. Overflow has no effect on a store.
- Store followed by load to the same word on the next cycle: the load reads the newly written data.
- Load followed by store to the same word: the load gets the old data.
- Stall: both registers hold. WE stays asserted if wb_we was 1; rewriting the same value is harmless.
- Reset (any cycle, including mid-stall):
  - Clears all EX/MEM and MEM/WB control bits, Rw, Di, branch_target and data to 0.
  - All outputs read 0 the cycle after reset.
  - Memory contents are not reset.
  - reset overrides stall.
- A bubble (ex_valid = 0) never writes memory or the register file and never asserts pc_src.

Decomposition:
- Shared package mips_pkg: REG_W = 5, WORD_W = 32, the control-bundle struct {MW, BR, MR, RW} and the zero register constant R0.
- One natural sub-module: data_mem (synchronous write, asynchronous read, DEPTH_LOG2 parameter).
- The pipeline registers and write-back mux stay in mem_wb_unit.

Test Plan:
- Reset: hold reset 2 cycles with random inputs, then release → WE = 0, pc_src = 0, Rw = 0, Di = 0 for both cycles and the first cycle after.
- R-type add: ALUout = 0x0000_0007, Rw_out = 9, RW = 1, MR = 0, ex_valid = 1 at edge N → Rw = 9, Di = 7, WE = 1 after edge N+1. fwd_mem_rw = 9 and fwd_mem_we = 1 after edge N.
- Store then load: MW = 1, ALUout = 0x10, BB = 0xDEADBEEF; next cycle MR = 1, RW = 1, ALUout = 0x10, Rw_out = 4 → Di = 0xDEADBEEF, WE = 1, Rw = 4. Repeat with ALUout = 0x410: same word index (wrap) → same data.
- Branch: BR = 1, Zero = 1, newPC = 0x40 → pc_src = 1, branch_target = 0x40 for one cycle after edge N. With Zero = 0 → pc_src = 0. With ex_valid = 0 → pc_src = 0.
- Kill cases: Overflow = 1 with RW = 1, Rw_out = 3 → WE = 0. Rw_out = 0, RW = 1, REG_ZERO_WE = 0 → WE = 0.
- Stall and reset: stall = 1 for 3 cycles during a store → memory written at most once, outputs held. Assert reset mid-stall → all outputs 0 the next cycle, and a previously stored word is still readable.
